imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Registered, parametrised immediate generator for the pipelined core: sits between ID
//  and EX and replaces the combinational extender there.
//  Accepts instr[31:7] plus a `param.v` sext_op code over a valid/ready handshake.
//  Returns the XLEN-wide extended immediate and a pass-through tag one cycle later.
//  Uses a 2-entry (output + skid) buffer, so throughput is full and in_ready is registered.
// PARAMETERS
//  XLEN   32  output width; legal values 32 or 64
//  TAG_W  5   width of the sideband tag carried alongside each immediate (e.g. rd/ROB id)
// PORTS
//  clk          in   1      core clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      upstream has an instruction
//  in_ready     out  1      block can accept this cycle
//  instruction  in   25     instr[31:7]
//  sext_op      in   3      extension select, `param.v` macros (`I_type_ext_unsigned`, ..., `J_type_ext`)
//  in_tag       in   TAG_W  sideband, returned unchanged
//  out_valid    out  1      ext_number/out_tag valid
//  out_ready    in   1      downstream consumes when out_valid & out_ready
//  ext_number   out  XLEN   extended immediate
//  out_tag      out  TAG_W  tag of the item in ext_number
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, skid_valid=0, in_ready=1, ext_number=0, out_tag=0.
//  Reset takes effect immediately mid-transfer; any buffered items are dropped.
//  Extension rules (s = instr[31] = instruction[24], sign-filled to XLEN):
//   - I_unsigned: zero-extend instruction[24:13].
//   - I: sign-extend instruction[24:13].
//   - S: sign-extend {[24:18],[4:0]}.
//   - B: sign-extend the 12-bit {s,[0],[23:18],[4:1]}. This is the halfword offset imm[12:1]; no LSB zero appended.
//   - U: {[24:5],12'b0}; for XLEN=64, bits 63:32 are filled with s.
//   - J: sign-extend the 20-bit {s,[12:5],[13],[23:14]}. This is imm[20:1], in halfword units.
//   - Undefined code: ext_number=0 (see CONFIGURATION).
//  Extension is combinational on the input; only the result and tag are registered.
//  Storage: output register (out_valid) plus one skid register (skid_valid).
//  in_ready = ~skid_valid, driven from a flop with no combinational path from out_ready.
//  Accept = in_valid & in_ready.
//  Each cycle (pop = out_valid & out_ready):
//   - pop & skid_valid: skid -> output. If an item is also accepted, it goes to skid.
//   - Accept & (~out_valid | pop) & ~skid_valid: new item -> output register.
//   - Accept & out_valid & ~pop: new item -> skid; in_ready falls next cycle.
//   - pop & ~accept & ~skid_valid: out_valid -> 0.
//  Latency: 1 cycle from accept to out_valid when the output register is free.
//  Order is strictly FIFO; no item is dropped or duplicated.
//  Full (both entries valid): in_ready=0, so in_valid is ignored.
//  Simultaneous pop and accept while full is impossible, because in_ready is already 0.
//  While out_valid=1 & out_ready=0: ext_number/out_tag stay stable.
//  out_valid never drops without a pop.
//  No combinational path from any input to in_ready or out_valid.
// CONFIGURATION
//  IMM_ILLEGAL_CHK_EN defined:
//   - Adds output port out_illegal (1 bit), buffered with each item and reset to 0.
//   - out_illegal=1 for a sext_op outside the six `param.v` codes; ext_number=0.
//   - For XLEN=64, also set for I_unsigned when instruction[24:19]!=0 (illegal shamt field).
//  IMM_ILLEGAL_CHK_EN undefined:
//   - Port is absent.
//   - Undefined codes silently yield ext_number=0; no other behaviour changes.
// TESTING
//  1. Reset: drive rst_n=0 mid-stream with both entries full.
//     -> Same cycle: out_valid=0, in_ready=1, ext_number=0.
//  2. XLEN=32, I, instruction=0xFFF00093>>7, out_ready=1.
//     -> Next cycle out_valid=1, ext_number=0xFFFFFFFF.
//     Also: U with 0x12345037>>7 -> 0x12345000.
//  3. XLEN=64: U with 0x80000037>>7 -> 0xFFFFFFFF80000000.
//     J with 0xFFDFF06F>>7 (jal -4) -> 0xFFFFFFFFFFFFFFFE (-2, halfword units).
//  4. Backpressure: out_ready=0, push tags 1,2.
//     -> in_ready=0 after the 2nd accept; a 3rd in_valid is not taken.
//     Then raise out_ready -> tags 1 then 2 on consecutive cycles; in_ready returns to 1.
//  5. Streaming: in_valid=1 and random out_ready for 1000 items.
//     -> Output sequence equals the reference-model sequence.
//     -> Throughput is 1 item/cycle whenever out_ready=1.
//  6. With IMM_ILLEGAL_CHK_EN: sext_op=3'b111 -> out_illegal=1, ext_number=0.
//     XLEN=64, slli with shamt=63 -> out_illegal=0, ext_number=0x3F.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator behind a 2-entry (output + skid) buffer.
// Optional feature macro IMM_ILLEGAL_CHK_EN adds the out_illegal flag buffered with each item.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      instruction,
    input  logic [2:0]       sext_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef IMM_ILLEGAL_CHK_EN
    output logic             out_illegal,
`endif
    output logic [XLEN-1:0]  ext_number,
    output logic [TAG_W-1:0] out_tag
);
    localparam logic [2:0] I_UNSIGNED = 3'd0;
    localparam logic [2:0] I_TYPE     = 3'd1;
    localparam logic [2:0] S_TYPE     = 3'd2;
    localparam logic [2:0] B_TYPE     = 3'd3;
    localparam logic [2:0] U_TYPE     = 3'd4;
    localparam logic [2:0] J_TYPE     = 3'd5;
    logic            s;
    logic [31:0]     imm32;
    logic [XLEN-1:0] ext;
    assign s = instruction[24];
    // Every form is first built sign-correct at 32 bits, then sign-extended to XLEN.
    assign imm32 = (sext_op == I_UNSIGNED) ? {20'b0, instruction[24:13]} :
                   (sext_op == I_TYPE)     ? {{20{s}}, instruction[24:13]} :
                   (sext_op == S_TYPE)     ? {{20{s}}, instruction[24:18], instruction[4:0]} :
                   (sext_op == B_TYPE)     ? {{20{s}}, s, instruction[0], instruction[23:18], instruction[4:1]} :
                   (sext_op == U_TYPE)     ? {instruction[24:5], 12'b0} :
                   (sext_op == J_TYPE)     ? {{12{s}}, s, instruction[12:5], instruction[13], instruction[23:14]} :
                   32'b0;
    assign ext = XLEN'($signed(imm32));
`ifdef IMM_ILLEGAL_CHK_EN
    localparam int PW = XLEN + TAG_W + 1;
    logic ill;
    assign ill = (sext_op > J_TYPE) ||
                 ((XLEN == 64) && (sext_op == I_UNSIGNED) && (instruction[24:19] != 6'b0));
    logic [PW-1:0] in_pl, out_pl, skid_pl;
    assign in_pl = {ill, ext, in_tag};
    assign {out_illegal, ext_number, out_tag} = out_pl;
`else
    localparam int PW = XLEN + TAG_W;
    logic [PW-1:0] in_pl, out_pl, skid_pl;
    assign in_pl = {ext, in_tag};
    assign {ext_number, out_tag} = out_pl;
`endif
    logic skid_valid;
    assign in_ready = ~skid_valid;
    // skid_valid implies out_valid, so a pop while full is just out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_pl     <= '0;
            skid_pl    <= '0;
        end else if (skid_valid) begin
            if (out_ready) begin
                out_pl     <= skid_pl;
                skid_valid <= 1'b0;
            end
        end else if (in_valid) begin
            if (!out_valid || out_ready) begin
                out_pl    <= in_pl;
                out_valid <= 1'b1;
            end else begin
                skid_pl    <= in_pl;
                skid_valid <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: XLEN=32/64 instances checked against a queue model with vectors, handshake corners and a random stream
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [24:0] instruction = '0;
  logic [2:0]  sext_op = '0;
  logic [4:0]  in_tag = '0;
  logic        ir32, ov32, ir64, ov64;
  logic [31:0] ext32;
  logic [63:0] ext64;
  logic [4:0]  tag32, tag64;
  always #5 clk = ~clk;
`ifdef IMM_ILLEGAL_CHK_EN
  logic ill32, ill64;
`endif
  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
    .instruction(instruction), .sext_op(sext_op), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready),
`ifdef IMM_ILLEGAL_CHK_EN
    .out_illegal(ill32),
`endif
    .ext_number(ext32), .out_tag(tag32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64),
    .instruction(instruction), .sext_op(sext_op), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready),
`ifdef IMM_ILLEGAL_CHK_EN
    .out_illegal(ill64),
`endif
    .ext_number(ext64), .out_tag(tag64));
  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic [4:0]  tag;
  } sb_t;
  sb_t q[$];
  typedef struct {
    logic [24:0] ins;
    logic [2:0]  op;
    logic [4:0]  tag;
    logic [31:0] e32;
    logic [63:0] e64;
  } vec_t;
  vec_t vecs[11];
  int total = 0;
  int passed = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [24:0] ins, input logic [2:0] op);
    logic [63:0] raw;
    int w;
    case (op)
      3'd0: return 64'(ins[24:13]);
      3'd1: begin raw = 64'(ins[24:13]); w = 12; end
      3'd2: begin raw = 64'({ins[24:18], ins[4:0]}); w = 12; end
      3'd3: begin raw = 64'({ins[24], ins[0], ins[23:18], ins[4:1]}); w = 12; end
      3'd4: begin raw = 64'({ins[24:5], 12'b0}); w = 32; end
      3'd5: begin raw = 64'({ins[24], ins[12:5], ins[13], ins[23:14]}); w = 20; end
      default: return 64'd0;
    endcase
    if (raw[w-1]) raw = raw - (64'd1 << w);
    return raw;
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      sb_t e;
      chk("occ_out_valid", 64'(ov32), 64'(q.size() > 0));
      chk("occ_in_ready", 64'(ir32), 64'(q.size() < 2));
      if (ov32 && out_ready) begin
        if (q.size() == 0) chk("sb_unexpected_pop", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("sb_ext32", 64'(ext32), 64'(e.e32));
          chk("sb_ext64", ext64, e.e64);
          chk("sb_tag", {54'd0, ov64, tag64, tag32}, {54'd0, 1'b1, e.tag, e.tag});
        end
      end
      if (in_valid && ir32) begin
        e.e64 = model(instruction, sext_op);
        e.e32 = e.e64[31:0];
        e.tag = in_tag;
        q.push_back(e);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, cyc;
    bit acc;
    vecs[0]  = '{25'h1FFE001, 3'd1, 5'd1,  32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[1]  = '{25'h02468A0, 3'd4, 5'd2,  32'h12345000, 64'h0000000012345000};
    vecs[2]  = '{25'h1000000, 3'd4, 5'd3,  32'h80000000, 64'hFFFFFFFF80000000};
    vecs[3]  = '{25'h1FFBFE0, 3'd5, 5'd4,  32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE};
    vecs[4]  = '{25'h007E000, 3'd0, 5'd5,  32'h0000003F, 64'h000000000000003F};
    vecs[5]  = '{25'h1FFFFFF, 3'd7, 5'd6,  32'h00000000, 64'h0000000000000000};
    vecs[6]  = '{25'h0040002, 3'd2, 5'd7,  32'h00000022, 64'h0000000000000022};
    vecs[7]  = '{25'h1FFFFFF, 3'd2, 5'd8,  32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[8]  = '{25'h0000001, 3'd3, 5'd9,  32'h00000400, 64'h0000000000000400};
    vecs[9]  = '{25'h1000000, 3'd3, 5'd10, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800};
    vecs[10] = '{25'h1FFE000, 3'd0, 5'd11, 32'h00000FFF, 64'h0000000000000FFF};
    #3;
    chk("rst_out_valid", 64'(ov32), 64'd0);
    chk("rst_in_ready", 64'(ir32), 64'd1);
    chk("rst_ext", ext64 | 64'(ext32), 64'd0);
    chk("rst_tag", 64'(tag32), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      instruction = vecs[i].ins;
      sext_op = vecs[i].op;
      in_tag = vecs[i].tag;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 64'(ov32), 64'd1);
      chk($sformatf("vec%0d_ext32", i), 64'(ext32), 64'(vecs[i].e32));
      chk($sformatf("vec%0d_ext64", i), ext64, vecs[i].e64);
      chk($sformatf("vec%0d_tag", i), 64'(tag32), 64'(vecs[i].tag));
`ifdef IMM_ILLEGAL_CHK_EN
      chk($sformatf("vec%0d_ill32", i), 64'(ill32), 64'(vecs[i].op > 3'd5));
      chk($sformatf("vec%0d_ill64", i), 64'(ill64),
        64'((vecs[i].op > 3'd5) || (vecs[i].op == 3'd0 && vecs[i].ins[24:19] != 6'd0)));
`endif
    end
    tick();
    chk("table_drained", 64'(ov32), 64'd0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    sext_op = 3'd1;
    instruction = 25'h0123456;
    in_tag = 5'd1;
    tick();
    in_tag = 5'd2;
    tick();
    chk("bp_full_in_ready", 64'(ir32), 64'd0);
    in_tag = 5'd3;
    tick();
    tick();
    chk("bp_still_full", 64'(ir32), 64'd0);
    chk("bp_hold_tag", 64'(tag32), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_second_tag", 64'(tag32), 64'd2);
    chk("bp_second_valid", 64'(ov32), 64'd1);
    chk("bp_ready_back", 64'(ir32), 64'd1);
    tick();
    chk("bp_empty", 64'(ov32), 64'd0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_tag = 5'd9;
    instruction = 25'h1FFFFFF;
    tick();
    tick();
    in_valid = 1'b0;
    chk("pre_rst_full", 64'(ir32), 64'd0);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", 64'(ov32 | ov64), 64'd0);
    chk("midrst_in_ready", 64'(ir32 & ir64), 64'd1);
    chk("midrst_ext", ext64 | 64'(ext32), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    n = 0;
    cyc = 0;
    in_valid = 1'b1;
    instruction = 25'($urandom);
    sext_op = 3'($urandom);
    in_tag = 5'($urandom);
    while (n < 1000 && cyc < 20000) begin
      out_ready = 1'($urandom);
      acc = ir32;
      tick();
      cyc++;
      if (acc) begin
        n++;
        instruction = 25'($urandom);
        sext_op = 3'($urandom);
        in_tag = 5'($urandom);
      end
    end
    chk("stream_items", 64'(n), 64'd1000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("stream_drained", 64'(q.size()), 64'd0);
    $display("%s: %0d errors, %0d/%0d checks passed", (errors == 0) ? "PASS" : "FAIL", errors, passed, total);
    $finish;
  end
endmodule
